// File: rtl/apb_master_minimal_pkg.sv
// apb_master_minimal_pkg: FSM state encoding and APB request/response types
package apb_master_minimal_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } t_state;

  typedef struct packed {
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
  } t_apb_request;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        perr;
  } t_apb_response;

endpackage

// File: rtl/apb_master_minimal.sv
// apb_master_minimal: single-transfer APB master; ACCESS timeout when APB_MASTER_MINIMAL_TIMEOUT_EN is defined
module apb_master_minimal
  import apb_master_minimal_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk__enable,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ack,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_timeout,
  output logic [31:0] apb_request__paddr,
  output logic        apb_request__psel,
  output logic        apb_request__penable,
  output logic        apb_request__pwrite,
  output logic [31:0] apb_request__pwdata,
  input  logic [31:0] apb_response__prdata,
  input  logic        apb_response__pready,
  input  logic        apb_response__perr
);

  t_state        r_state;
  t_apb_request  r_req;
  t_apb_response w_rsp;
  logic          r_resp_valid;
  logic          r_resp_err;
  logic [31:0]   r_resp_rdata;

  assign w_rsp = '{prdata: apb_response__prdata, pready: apb_response__pready, perr: apb_response__perr};

  assign req_ready            = (r_state == S_IDLE);
  assign resp_valid           = r_resp_valid;
  assign resp_rdata           = r_resp_rdata;
  assign resp_err             = r_resp_err;
  assign apb_request__paddr   = r_req.paddr;
  assign apb_request__psel    = r_req.psel;
  assign apb_request__penable = r_req.penable;
  assign apb_request__pwrite  = r_req.pwrite;
  assign apb_request__pwdata  = r_req.pwdata;

`ifdef APB_MASTER_MINIMAL_TIMEOUT_EN
  logic       r_resp_timeout;
  logic [7:0] r_tcnt;
  logic [7:0] w_tcnt_next;
  logic       w_expire;

  assign w_tcnt_next  = r_tcnt + 8'd1;
  // expire on the ACCESS cycle that would bring the stalled-cycle count to the limit
  assign w_expire     = (w_tcnt_next == TIMEOUT_CYCLES);
  assign resp_timeout = r_resp_timeout;
`else
  logic w_unused;

  assign w_unused     = ^TIMEOUT_CYCLES;
  assign resp_timeout = 1'b0;
`endif

  // transfer sequencer: IDLE -> SETUP -> ACCESS (wait for pready) -> RESP (wait for ack)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_req        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
`ifdef APB_MASTER_MINIMAL_TIMEOUT_EN
      r_resp_timeout <= 1'b0;
      r_tcnt         <= '0;
`endif
    end else if (clk__enable) begin
      case (r_state)
        S_IDLE:
          if (req_valid) begin
            r_state       <= S_SETUP;
            r_req.paddr   <= req_addr;
            r_req.pwrite  <= req_write;
            r_req.pwdata  <= req_wdata;
            r_req.psel    <= 1'b1;
            r_req.penable <= 1'b0;
          end
        S_SETUP: begin
          r_state       <= S_ACCESS;
          r_req.penable <= 1'b1;
`ifdef APB_MASTER_MINIMAL_TIMEOUT_EN
          r_tcnt <= '0;
`endif
        end
        S_ACCESS:
          // a pready arriving on the expiry cycle still completes normally
          if (w_rsp.pready) begin
            r_state       <= S_RESP;
            r_req.psel    <= 1'b0;
            r_req.penable <= 1'b0;
            r_resp_valid  <= 1'b1;
            r_resp_rdata  <= r_req.pwrite ? 32'h0 : w_rsp.prdata;
            r_resp_err    <= w_rsp.perr;
`ifdef APB_MASTER_MINIMAL_TIMEOUT_EN
            r_resp_timeout <= 1'b0;
          end else if (w_expire) begin
            r_state        <= S_RESP;
            r_req.psel     <= 1'b0;
            r_req.penable  <= 1'b0;
            r_resp_valid   <= 1'b1;
            r_resp_rdata   <= 32'h0;
            r_resp_err     <= 1'b1;
            r_resp_timeout <= 1'b1;
          end else begin
            r_tcnt <= w_tcnt_next;
`endif
          end
        S_RESP:
          if (resp_ack) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
          end
        default: r_state <= S_IDLE;
      endcase
    end

endmodule

// File: tb/tb_apb_master_minimal.sv
// tb_apb_master_minimal: scoreboard-driven scenario bench for apb_master_minimal
module tb_apb_master_minimal;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk__enable = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ack = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        perr = 1'b0;

  logic [33:0] sb_q[$];
  logic [33:0] exp;
  int          n_checks = 0;
  int          n_errors = 0;

  apb_master_minimal #(.TIMEOUT_CYCLES(8'd4)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .clk__enable          (clk__enable),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_addr             (req_addr),
    .req_write            (req_write),
    .req_wdata            (req_wdata),
    .resp_valid           (resp_valid),
    .resp_ack             (resp_ack),
    .resp_rdata           (resp_rdata),
    .resp_err             (resp_err),
    .resp_timeout         (resp_timeout),
    .apb_request__paddr   (paddr),
    .apb_request__psel    (psel),
    .apb_request__penable (penable),
    .apb_request__pwrite  (pwrite),
    .apb_request__pwdata  (pwdata),
    .apb_response__prdata (prdata),
    .apb_response__pready (pready),
    .apb_response__perr   (perr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++;
    if ({req_ready, psel, penable, pwrite, paddr, pwdata, resp_valid, resp_rdata, resp_err, resp_timeout} !== {1'b1, 3'b000, 64'h0, 1'b0, 32'h0, 2'b00}) begin
      n_errors++;
      $display("FAIL reset_values: ready=%b psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b rdata=%h err=%b to=%b, want ready=1 and all else 0",
               req_ready, psel, penable, pwrite, paddr, pwdata, resp_valid, resp_rdata, resp_err, resp_timeout);
    end
    reset_n = 1'b1;
    step();
    n_checks++;
    if ({req_ready, psel, resp_valid} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_release: ready/psel/rv=%b want 100", {req_ready, psel, resp_valid});
    end
  endtask

  task automatic test_read_fast();
    resp_ack = 1'b1;
    pready   = 1'b1;
    prdata   = 32'hDEADBEEF;
    sb_q.push_back({32'hDEADBEEF, 1'b0, 1'b0});
    issue(32'h8, 1'b0, 32'h0);
    n_checks++;
    if ({psel, penable, pwrite, paddr, req_ready, resp_valid} !== {3'b100, 32'h8, 2'b00}) begin
      n_errors++;
      $display("FAIL read_setup: psel=%b pen=%b pwr=%b paddr=%h ready=%b rv=%b want 1 0 0 8 0 0", psel, penable, pwrite, paddr, req_ready, resp_valid);
    end
    step();
    n_checks++;
    if ({psel, penable, paddr, resp_valid} !== {2'b11, 32'h8, 1'b0}) begin
      n_errors++;
      $display("FAIL read_access: psel=%b pen=%b paddr=%h rv=%b want 1 1 8 0", psel, penable, paddr, resp_valid);
    end
    step();
    pready = 1'b0;
    exp = sb_q.size() != 0 ? sb_q.pop_front() : 'x;
    n_checks++;
    if ({psel, penable, resp_valid, resp_rdata, resp_err, resp_timeout} !== {3'b001, exp}) begin
      n_errors++;
      $display("FAIL read_resp: psel=%b pen=%b rv=%b data/err/to=%h want 0 0 1 %h", psel, penable, resp_valid, {resp_rdata, resp_err, resp_timeout}, exp);
    end
    step();
    resp_ack = 1'b0;
    n_checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL read_ready_again: ready=%b rv=%b want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_write_wait();
    prdata = 32'hFFFFFFFF;
    sb_q.push_back({32'h0, 1'b0, 1'b0});
    issue(32'hC, 1'b1, 32'h5A);
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({psel, penable, pwrite, paddr, pwdata, resp_valid} !== {3'b111, 32'hC, 32'h5A, 1'b0}) begin
        n_errors++;
        $display("FAIL write_wait_%0d: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b want 1 1 1 c 5a 0", i, psel, penable, pwrite, paddr, pwdata, resp_valid);
      end
      step();
    end
    n_checks++;
    if ({psel, penable, resp_valid} !== 3'b110) begin
      n_errors++;
      $display("FAIL write_still_access: psel/pen/rv=%b want 110", {psel, penable, resp_valid});
    end
    pready = 1'b1;
    step();
    pready = 1'b0;
    exp = sb_q.size() != 0 ? sb_q.pop_front() : 'x;
    n_checks++;
    if ({resp_valid, resp_rdata, resp_err, resp_timeout} !== {1'b1, exp}) begin
      n_errors++;
      $display("FAIL write_resp: rv=%b data/err/to=%h want 1 %h", resp_valid, {resp_rdata, resp_err, resp_timeout}, exp);
    end
    resp_ack = 1'b1;
    step();
    resp_ack = 1'b0;
  endtask

  task automatic test_read_err();
    sb_q.push_back({32'h1234, 1'b1, 1'b0});
    issue(32'h10, 1'b0, 32'h0);
    step();
    pready = 1'b1;
    perr   = 1'b1;
    prdata = 32'h1234;
    step();
    pready    = 1'b0;
    perr      = 1'b0;
    prdata    = 32'h0;
    req_valid = 1'b1;
    req_addr  = 32'h99;
    exp = sb_q.size() != 0 ? sb_q.pop_front() : 'x;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({resp_valid, req_ready, psel, resp_rdata, resp_err, resp_timeout} !== {3'b100, exp}) begin
        n_errors++;
        $display("FAIL err_hold_%0d: rv=%b ready=%b psel=%b data/err/to=%h want 1 0 0 %h", i, resp_valid, req_ready, psel, {resp_rdata, resp_err, resp_timeout}, exp);
      end
      step();
    end
    req_valid = 1'b0;
    resp_ack  = 1'b1;
    step();
    resp_ack = 1'b0;
    n_checks++;
    if ({req_ready, resp_valid, psel} !== 3'b100) begin
      n_errors++;
      $display("FAIL err_release: ready/rv/psel=%b want 100", {req_ready, resp_valid, psel});
    end
  endtask

  task automatic test_timeout();
`ifdef APB_MASTER_MINIMAL_TIMEOUT_EN
    sb_q.push_back({32'h0, 1'b1, 1'b1});
    prdata = 32'h77;
    issue(32'h20, 1'b0, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({psel, penable, resp_valid} !== 3'b110) begin
        n_errors++;
        $display("FAIL timeout_wait_%0d: psel/pen/rv=%b want 110", i, {psel, penable, resp_valid});
      end
      step();
    end
    step();
`else
    sb_q.push_back({32'hCAFEF00D, 1'b0, 1'b0});
    issue(32'h20, 1'b0, 32'h0);
    step();
    repeat (100) step();
    n_checks++;
    if ({psel, penable, resp_valid, resp_timeout} !== 4'b1100) begin
      n_errors++;
      $display("FAIL no_timeout: psel/pen/rv/to=%b want 1100", {psel, penable, resp_valid, resp_timeout});
    end
    pready = 1'b1;
    prdata = 32'hCAFEF00D;
    step();
    pready = 1'b0;
`endif
    exp = sb_q.size() != 0 ? sb_q.pop_front() : 'x;
    n_checks++;
    if ({psel, resp_valid, resp_rdata, resp_err, resp_timeout} !== {2'b01, exp}) begin
      n_errors++;
      $display("FAIL timeout_resp: psel=%b rv=%b data/err/to=%h want 0 1 %h", psel, resp_valid, {resp_rdata, resp_err, resp_timeout}, exp);
    end
    resp_ack = 1'b1;
    step();
    resp_ack = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    issue(32'h40, 1'b1, 32'hABCD);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({psel, penable, paddr, pwdata, resp_valid} !== {2'b00, 64'h0, 1'b0}) begin
      n_errors++;
      $display("FAIL async_reset: psel=%b pen=%b paddr=%h pwdata=%h rv=%b want all 0", psel, penable, paddr, pwdata, resp_valid);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    pready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({req_ready, psel, resp_valid} !== 3'b100) begin
        n_errors++;
        $display("FAIL post_reset_%0d: ready/psel/rv=%b want 100", i, {req_ready, psel, resp_valid});
      end
    end
    pready = 1'b0;
  endtask

  task automatic test_clk_enable();
    sb_q.push_back({32'h55AA55AA, 1'b0, 1'b0});
    issue(32'h80, 1'b0, 32'h0);
    clk__enable = 1'b0;
    pready = 1'b1;
    perr   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({psel, penable, paddr, resp_valid, req_ready} !== {2'b10, 32'h80, 2'b00}) begin
        n_errors++;
        $display("FAIL freeze_setup_%0d: psel=%b pen=%b paddr=%h rv=%b ready=%b want 1 0 80 0 0", i, psel, penable, paddr, resp_valid, req_ready);
      end
    end
    clk__enable = 1'b1;
    pready = 1'b0;
    perr   = 1'b0;
    step();
    n_checks++;
    if ({psel, penable, resp_valid} !== 3'b110) begin
      n_errors++;
      $display("FAIL after_freeze_access: psel/pen/rv=%b want 110", {psel, penable, resp_valid});
    end
    clk__enable = 1'b0;
    pready = 1'b1;
    prdata = 32'h0BAD0BAD;
    step();
    n_checks++;
    if ({psel, penable, resp_valid} !== 3'b110) begin
      n_errors++;
      $display("FAIL freeze_access: psel/pen/rv=%b want 110", {psel, penable, resp_valid});
    end
    clk__enable = 1'b1;
    prdata = 32'h55AA55AA;
    step();
    pready = 1'b0;
    exp = sb_q.size() != 0 ? sb_q.pop_front() : 'x;
    n_checks++;
    if ({resp_valid, resp_rdata, resp_err, resp_timeout} !== {1'b1, exp}) begin
      n_errors++;
      $display("FAIL freeze_resp: rv=%b data/err/to=%h want 1 %h", resp_valid, {resp_rdata, resp_err, resp_timeout}, exp);
    end
    resp_ack = 1'b1;
    step();
    resp_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, r;
    int dly;
    resp_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a   = $urandom;
      d   = $urandom;
      r   = $urandom;
      dly = $urandom_range(0, 2);
      sb_q.push_back({k[0] ? 32'h0 : r, k == 2, 1'b0});
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_ready_%0d: ready=%b want 1", k, req_ready);
      end
      issue(a, k[0], d);
      step();
      repeat (dly) step();
      pready = 1'b1;
      perr   = (k == 2);
      prdata = r;
      step();
      pready = 1'b0;
      perr   = 1'b0;
      for (int n = 0; n < 8 && !resp_valid; n++) step();
      exp = sb_q.size() != 0 ? sb_q.pop_front() : 'x;
      n_checks++;
      if ({resp_valid, resp_rdata, resp_err, resp_timeout} !== {1'b1, exp}) begin
        n_errors++;
        $display("FAIL b2b_resp_%0d: rv=%b data/err/to=%h want 1 %h", k, resp_valid, {resp_rdata, resp_err, resp_timeout}, exp);
      end
      step();
    end
    resp_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_fast();
    test_write_wait();
    test_read_err();
    test_timeout();
    test_reset_mid_access();
    test_clk_enable();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
